// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button peripheral.
// Holds default register addresses, release-event bit offset and counter width function.
package btn_pkg;

    localparam logic [11:0] STAT_ADDR_DEF = 12'h078;
    localparam logic [11:0] EDGE_ADDR_DEF = 12'h07C;
    localparam int unsigned REL_OFS       = 8;

    // Smallest width able to hold the value n (clog2(n+1)), never below 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((longint'(1) << w) < (longint'(n) + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_driver_if.sv
// IO bus slice between BUS (master) and a memory-mapped peripheral (slave).
// Ports: io_en, io_we, io_addr, io_write_data (to slave); io_read_data (to master).
interface btn_driver_if;

    logic        io_en;
    logic        io_we;
    logic [11:0] io_addr;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;

    modport master (
        output io_en, io_we, io_addr, io_write_data,
        input  io_read_data
    );

    modport slave (
        input  io_en, io_we, io_addr, io_write_data,
        output io_read_data
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, saturating stability counter and debounced level.
// Ports: clk, rst, btn_i (raw async), stable_o, rise_o/fall_o (one-cycle, after stable changes).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned    CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CMAX = '1;

    logic          meta_q, sync_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync_q;
                rise_d   = sync_q;
                fall_d   = ~sync_q;
            end else if (cnt_q != CMAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            meta_q   <= btn_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/btn_driver.sv
// Button peripheral: debounced level (STAT) and sticky W1C press events (EDGE).
// Ports: clk, rst, io (btn_driver_if.slave), device_btn, btn_pending.
// Macro BTN_RELEASE_EVT_EN adds release events in EDGE bits [8+NUM_BTN-1:8].
module btn_driver
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter logic [11:0] STAT_ADDR       = STAT_ADDR_DEF,
    parameter logic [11:0] EDGE_ADDR       = EDGE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    btn_driver_if.slave        io,
    input  logic [NUM_BTN-1:0] device_btn,
    output logic               btn_pending
);

    logic [NUM_BTN-1:0] stable, rise, fall;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [31:0]        rdata;
    logic               rd_stat, rd_edge, wr_edge;

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (device_btn[i]),
            .stable_o(stable[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    assign rd_stat = io.io_en && !io.io_we && (io.io_addr == STAT_ADDR);
    assign rd_edge = io.io_en && !io.io_we && (io.io_addr == EDGE_ADDR);
    assign wr_edge = io.io_en &&  io.io_we && (io.io_addr == EDGE_ADDR);

    // New events are OR-ed in after the clear so a same-cycle set wins.
    always_comb begin
        press_d = press_q;
        if (wr_edge) begin
            press_d = press_q & ~io.io_write_data[NUM_BTN-1:0];
        end
        press_d = press_d | rise;
    end

`ifdef BTN_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] rel_q, rel_d;

    always_comb begin
        rel_d = rel_q;
        if (wr_edge) begin
            rel_d = rel_q & ~io.io_write_data[REL_OFS +: NUM_BTN];
        end
        rel_d = rel_d | fall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rel_q <= '0;
        end else begin
            rel_q <= rel_d;
        end
    end

    assign btn_pending = (|press_q) | (|rel_q);
`else
    assign btn_pending = |press_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    // Zero when not selected so BUS can OR all peripheral read buses.
    always_comb begin
        rdata = '0;
        if (rd_stat) begin
            rdata[NUM_BTN-1:0] = stable;
        end else if (rd_edge) begin
            rdata[NUM_BTN-1:0] = press_q;
`ifdef BTN_RELEASE_EVT_EN
            rdata[REL_OFS +: NUM_BTN] = rel_q;
`endif
        end
    end

    assign io.io_read_data = rdata;

    logic unused_ok;
    assign unused_ok = ^{io.io_write_data, fall};

endmodule

// File: tb/tb_btn_driver.sv
// Randomised self-checking bench for btn_driver against a cycle reference model.
// Uses NUM_BTN=5, DEBOUNCE_CYCLES=4; honours BTN_RELEASE_EVT_EN.
module tb_btn_driver;

    localparam int          NB   = 5;
    localparam int          DC   = 4;
    localparam logic [11:0] STAT = 12'h078;
    localparam logic [11:0] EDGE = 12'h07C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] device_btn = '0;
    logic          btn_pending;

    btn_driver_if bus();

    btn_driver #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DC),
        .STAT_ADDR      (STAT),
        .EDGE_ADDR      (EDGE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (bus),
        .device_btn (device_btn),
        .btn_pending(btn_pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model: inputs reach the debouncer 2 clocks late; the level
    // flips after DC consecutive mismatching cycles; an event appears one
    // clock after the level flips; W1C loses to a simultaneous new event.
    bit [NB-1:0] m_s1, m_s2, m_stab, m_rise, m_fall, m_press, m_rel;
    int          m_run [NB];

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0;
        m_rise = '0; m_fall = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic en, input logic we,
                                           input logic [11:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (en && !we && a == STAT) r = 32'(m_stab);
        else if (en && !we && a == EDGE) r = 32'(m_press) | (32'(m_rel) << 8);
        return r;
    endfunction

    task automatic m_clock(input logic [NB-1:0] b, input logic en, input logic we,
                           input logic [11:0] a, input logic [31:0] wd);
        bit [NB-1:0] nstab, nrise, nfall;
        bit [31:0]   clr;
        nstab = m_stab; nrise = '0; nfall = '0;
        for (int i = 0; i < NB; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DC) begin
                    nstab[i] = m_s2[i];
                    m_run[i] = 0;
                    if (m_s2[i]) nrise[i] = 1'b1;
                    else         nfall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        clr = (en && we && a == EDGE) ? wd : 32'h0;
        m_press = (m_press & ~clr[NB-1:0]) | m_rise;
`ifdef BTN_RELEASE_EVT_EN
        m_rel = (m_rel & ~clr[8 +: NB]) | m_fall;
`endif
        m_rise = nrise;
        m_fall = nfall;
        m_stab = nstab;
        m_s2   = m_s1;
        m_s1   = b;
    endtask

    task automatic step(input logic [NB-1:0] b, input logic en, input logic we,
                        input logic [11:0] a, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output logic pend);
        @(negedge clk);
        rst = 1'b0;
        device_btn = b;
        bus.io_en = en; bus.io_we = we; bus.io_addr = a; bus.io_write_data = wd;
        #1;
        rd = bus.io_read_data;
        pend = btn_pending;
        chk({tag, ":rd"}, rd, m_read(en, we, a));
        chk({tag, ":pend"}, 32'(pend), 32'(|{m_press, m_rel}));
        @(posedge clk);
        m_clock(b, en, we, a, wd);
    endtask

    task automatic do_reset(input logic [NB-1:0] b);
        @(negedge clk);
        rst = 1'b1;
        device_btn = b;
        bus.io_en = 1'b0; bus.io_we = 1'b0;
        @(posedge clk);
        m_reset();
    endtask

    task automatic idle(input logic [NB-1:0] b, input int n, input string tag);
        logic [31:0] rd;
        logic        p;
        for (int k = 0; k < n; k++) step(b, 1'b1, 1'b0, 12'h010, 32'h0, tag, rd, p);
    endtask

    logic [31:0] rd;
    logic        pend;

    initial begin
        bus.io_en = 1'b0; bus.io_we = 1'b0;
        bus.io_addr = '0; bus.io_write_data = '0;
        m_reset();

        do_reset('0);
        step('0, 1'b1, 1'b0, STAT, 32'h0, "rst_stat", rd, pend);
        chk("rst_stat_val", rd, 32'h0);
        step('0, 1'b1, 1'b0, EDGE, 32'h0, "rst_edge", rd, pend);
        chk("rst_edge_val", rd, 32'h0);
        chk("rst_pend_val", 32'(pend), 32'h0);

        idle(5'b00100, 10, "press2");
        step(5'b00100, 1'b1, 1'b0, STAT, 32'h0, "p2_stat", rd, pend);
        chk("p2_stat_val", rd, 32'h4);
        step(5'b00100, 1'b1, 1'b0, EDGE, 32'h0, "p2_edge", rd, pend);
        chk("p2_edge_val", rd, 32'h4);
        chk("p2_pend_val", 32'(pend), 32'h1);

        idle(5'b00101, 3, "glitch");
        idle(5'b00100, 8, "glitch_after");
        step(5'b00100, 1'b1, 1'b0, STAT, 32'h0, "gl_stat", rd, pend);
        chk("gl_stat_val", rd, 32'h4);
        step(5'b00100, 1'b1, 1'b0, EDGE, 32'h0, "gl_edge", rd, pend);
        chk("gl_edge_val", rd, 32'h4);

        idle(5'b00101, 10, "press0");
        step(5'b00101, 1'b1, 1'b0, EDGE, 32'h0, "w1c_pre", rd, pend);
        chk("w1c_pre_val", rd, 32'h5);
        step(5'b00101, 1'b1, 1'b1, EDGE, 32'h1, "w1c_1", rd, pend);
        step(5'b00101, 1'b1, 1'b0, EDGE, 32'h0, "w1c_1r", rd, pend);
        chk("w1c_1_val", rd, 32'h4);
        step(5'b00101, 1'b1, 1'b1, STAT, 32'hFFFF_FFFF, "w_stat", rd, pend);
        step(5'b00101, 1'b1, 1'b1, EDGE, 32'h4, "w1c_4", rd, pend);
        step(5'b00101, 1'b1, 1'b0, EDGE, 32'h0, "w1c_4r", rd, pend);
        chk("w1c_4_val", rd, 32'h0);
        chk("w1c_pend_val", 32'(pend), 32'h0);

        idle(5'b00111, 6, "setwin");
        step(5'b00111, 1'b1, 1'b1, EDGE, 32'h2, "setwin_w", rd, pend);
        step(5'b00111, 1'b1, 1'b0, EDGE, 32'h0, "setwin_r", rd, pend);
        chk("setwin_val", rd, 32'h2);

        idle(5'b01111, 10, "press3");
        step(5'b01111, 1'b1, 1'b0, EDGE, 32'h0, "p3_edge", rd, pend);
        chk("p3_edge_val", rd, 32'hA);
        idle(5'b01000, 3, "mid");
        do_reset(5'b01000);
        step(5'b01000, 1'b1, 1'b0, STAT, 32'h0, "mr_stat", rd, pend);
        chk("mr_stat_val", rd, 32'h0);
        step(5'b01000, 1'b1, 1'b0, EDGE, 32'h0, "mr_edge", rd, pend);
        chk("mr_edge_val", rd, 32'h0);
        idle(5'b01000, 5, "mr_hold");
        step(5'b01000, 1'b1, 1'b0, EDGE, 32'h0, "mr_edge2", rd, pend);
        chk("mr_edge2_val", rd, 32'h8);
        idle(5'b00000, 10, "rel3");
        step(5'b00000, 1'b1, 1'b0, EDGE, 32'h0, "rel3_edge", rd, pend);
`ifdef BTN_RELEASE_EVT_EN
        chk("rel3_edge_val", rd, 32'h808);
`else
        chk("rel3_edge_val", rd, 32'h8);
`endif

        begin
            logic [NB-1:0] pat;
            int            hold;
            pat = '0;
            hold = 0;
            for (int n = 0; n < 4000; n++) begin
                logic        en, we;
                logic [11:0] a;
                logic [31:0] wd;
                int          op;
                if (hold == 0) begin
                    pat  = NB'($urandom);
                    hold = $urandom_range(1, 9);
                end
                hold--;
                op = $urandom_range(0, 7);
                en = (op != 7);
                we = (op == 2 || op == 3 || op == 4);
                case (op)
                    0, 3:    a = STAT;
                    1, 2, 7: a = EDGE;
                    5:       a = 12'h07C ^ 12'h004;
                    default: a = 12'(($urandom & 32'hFFF) | 32'h001);
                endcase
                wd = $urandom;
                if (($urandom % 600) == 0) do_reset(pat);
                else step(pat, en, we, a, wd, "rand", rd, pend);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
